uart_bus_bridge: RTL and testbench
==================================

Name: uart_bus_bridge

Overview:
- Bus initiator driven by a host over UART; the opposite end of the memory-mapped data interface the CPU drives.
- Receives command frames from a UART receiver byte stream, performs one 32-bit read or write on the data bus, and returns a reply through a UART transmitter byte stream.
- Used for RAM preload and peripheral debug. The top-level data-bus mux gives it the bus while bus_req_o is high and bus_gnt_i is returned.

Parameters:
- TIMEOUT_CYCLES, 100000, maximum idle clocks between frame bytes before the frame is discarded (10 ms at 10 MHz).
- READ_LATENCY, 1, clocks from address presented to bus_rdata_i valid (1..4).

Ports:
- clk  in  1  system clock (10 MHz domain)
- reset  in  1  synchronous, active-high reset
- rx_data_i  in  8  received byte
- rx_valid_i  in  1  one-cycle strobe, rx_data_i valid; no backpressure
- tx_data_o  out  8  byte to transmit
- tx_valid_o  out  1  tx_data_o valid; held until accepted
- tx_ready_i  in  1  transmitter accepts byte when tx_valid_o && tx_ready_i
- bus_req_o  out  1  bridge requests data bus
- bus_gnt_i  in  1  bus granted; CPU stalled by top
- bus_addr_o  out  32  data address
- bus_wdata_o  out  32  write data
- bus_we_o  out  1  write enable, one cycle per write
- bus_rdata_i  in  32  read data
- busy_o  out  1  high whenever state != IDLE
- overrun_o  out  1  sticky: byte arrived while not accepting

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, overrun_o cleared. Reset mid-operation aborts immediately: bus_req_o and tx_valid_o drop on the next edge, with no partial write.
- Frame format (multi-byte fields MSB first):
  - Write: 0x57 'W', A3..A0, D3..D0.
  - Read: 0x52 'R', A3..A0.
- States: IDLE, ADDR, DATA, REQ, WRITE, RDWAIT, RESP.
- IDLE, on rx_valid_i:
  - 0x57 or 0x52: latch opcode, go to ADDR with byte count 0.
  - Any other byte: load reply 0x3F '?' (1 byte), go to RESP.
- ADDR: each rx_valid_i shifts the byte into addr (addr <= {addr[23:0], byte}). After the 4th byte, go to DATA if write, REQ if read.
- DATA: same shift into wdata. After the 4th byte, go to REQ.
- Timeout counter: reset on every accepted byte; counts only in ADDR/DATA. When it reaches TIMEOUT_CYCLES-1, return to IDLE with no reply and no bus access.
- REQ: bus_req_o=1, bus_addr_o driven. Wait indefinitely for bus_gnt_i. On the cycle gnt is seen, go to WRITE or RDWAIT.
- WRITE: exactly one cycle with bus_we_o=1, bus_wdata_o valid, bus_req_o=1. Then load reply 0x4B 'K' (1 byte) and go to RESP.
- RDWAIT:
  - bus_req_o=1, bus_we_o=0, count READ_LATENCY cycles.
  - Capture bus_rdata_i in the last counted cycle.
  - Drop bus_req_o, load a 4-byte reply (MSB first), go to RESP.
- bus_req_o is low in all states except REQ/WRITE/RDWAIT.
- RESP: tx_valid_o=1 with the current byte. On tx_valid_o && tx_ready_i, advance to the next byte. After the last byte is accepted, go to IDLE on the same edge. Throughput is one byte per cycle if tx_ready_i stays high. tx_data_o is stable while tx_valid_o && !tx_ready_i.
- Bytes arriving in REQ/WRITE/RDWAIT/RESP are dropped and set overrun_o.
- A byte arriving on the same cycle the FSM returns to IDLE is dropped (FSM is not yet in IDLE).
- Address is not range-checked and may wrap at 32 bits; any address is issued as-is.

Decomposition:
- Package uart_bridge_pkg:
  - state enum.
  - Opcode constants OP_WRITE=8'h57, OP_READ=8'h52.
  - Reply constants RSP_OK=8'h4B, RSP_ERR=8'h3F.
  - Frame length constants.
- Sub-module bridge_timeout_counter: load/clear/enable, parameterised width, terminal-count output. Everything else stays flat in one FSM module.

Test Plan:
- Write: send 57 00 00 10 04 DE AD BE EF with gnt tied 1 -> exactly one bus_we_o pulse, addr 0x00001004, wdata 0xDEADBEEF; then tx byte 0x4B; busy_o low afterwards.
- Read: send 52 00 00 20 00, model returns 0x0000A55A at READ_LATENCY=1 -> no bus_we_o; tx bytes 00 00 A5 5A in order; repeat with READ_LATENCY=3 -> same bytes.
- Grant stall: hold bus_gnt_i low 50 cycles after the last address byte -> bus_req_o high and no access for 50 cycles; access completes 1 cycle after gnt rises.
- Backpressure and overrun: tx_ready_i low 20 cycles during the read reply -> tx_data_o stable at the first byte; a stray rx byte in that window -> overrun_o=1, reply unchanged.
- Bad opcode and timeout: send 0x41 -> single reply 0x3F. Send 57 00 00 then idle TIMEOUT_CYCLES -> IDLE, no bus access, no tx. Then a full valid write -> succeeds.
- Reset mid-frame: assert reset during the DATA phase, then during RESP -> all outputs 0 next cycle, no bus_we_o pulse, overrun_o cleared, next frame processed normally.

Source files
------------

// File: rtl/uart_bus_bridge_pkg.sv
// Shared types and constants for the UART-driven data-bus bridge.
package uart_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_REQ,
        ST_WRITE,
        ST_RDWAIT,
        ST_RESP
    } state_t;

    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_READ  = 8'h52;
    localparam logic [7:0] RSP_OK   = 8'h4B;
    localparam logic [7:0] RSP_ERR  = 8'h3F;

    localparam int unsigned ADDR_BYTES     = 4;
    localparam int unsigned DATA_BYTES     = 4;
    localparam int unsigned RD_REPLY_BYTES = 4;
    localparam int unsigned ACK_BYTES      = 1;

    function automatic logic is_opcode(input logic [7:0] b);
        return (b == OP_WRITE) || (b == OP_READ);
    endfunction

endpackage

// File: rtl/uart_bus_bridge_if.sv
// UART byte streams plus the data-bus side of the bridge.
interface uart_bus_bridge_if;
    logic [7:0]  rx_data_i;
    logic        rx_valid_i;
    logic [7:0]  tx_data_o;
    logic        tx_valid_o;
    logic        tx_ready_i;
    logic        bus_req_o;
    logic        bus_gnt_i;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic        bus_we_o;
    logic [31:0] bus_rdata_i;
    logic        busy_o;
    logic        overrun_o;

    modport master (
        input  rx_data_i, rx_valid_i, tx_ready_i, bus_gnt_i, bus_rdata_i,
        output tx_data_o, tx_valid_o, bus_req_o, bus_addr_o, bus_wdata_o,
        output bus_we_o, busy_o, overrun_o
    );

    modport slave (
        output rx_data_i, rx_valid_i, tx_ready_i, bus_gnt_i, bus_rdata_i,
        input  tx_data_o, tx_valid_o, bus_req_o, bus_addr_o, bus_wdata_o,
        input  bus_we_o, busy_o, overrun_o
    );
endinterface

// File: rtl/uart_bus_bridge_timeout_counter.sv
// Inter-byte idle counter with clear/load/enable and a terminal-count flag.
module bridge_timeout_counter #(
    parameter int unsigned WIDTH    = 17,
    parameter int unsigned TERMINAL = 99999
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clear,
    input  logic             enable,
    output logic             terminal_c
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (enable) begin
            count <= count + WIDTH'(1);
        end
    end

    assign terminal_c = (count == WIDTH'(TERMINAL));

endmodule

// File: rtl/uart_bus_bridge.sv
// Frame parser, single-access bus initiator and reply serializer for a UART host.
module uart_bus_bridge
    import uart_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter int unsigned READ_LATENCY   = 1
) (
    input  logic              clk,
    input  logic              reset,
    uart_bus_bridge_if.master bif
);

    localparam int unsigned TO_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned LAT_W = 2;

    state_t             state;
    logic               is_write;
    logic [1:0]         byte_cnt;
    logic [31:0]        addr;
    logic [31:0]        wdata;
    logic [31:0]        reply;
    logic [2:0]         reply_left;
    logic [LAT_W-1:0]   lat_cnt;
    logic               bus_req;
    logic               bus_we;
    logic               tx_valid;
    logic               busy;
    logic               overrun;
    logic               in_frame_c;
    logic               timeout_c;
    logic               dropping_c;

    assign in_frame_c = (state == ST_ADDR) || (state == ST_DATA);
    assign dropping_c = (state == ST_REQ) || (state == ST_WRITE) ||
                        (state == ST_RDWAIT) || (state == ST_RESP);

    // Idle time only matters while a frame is partially received.
    bridge_timeout_counter #(
        .WIDTH    (TO_W),
        .TERMINAL (TIMEOUT_CYCLES - 1)
    ) u_timeout (
        .clk        (clk),
        .reset      (reset),
        .load       (1'b0),
        .load_val   (TO_W'(0)),
        .clear      (bif.rx_valid_i || !in_frame_c),
        .enable     (in_frame_c),
        .terminal_c (timeout_c)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            is_write   <= 1'b0;
            byte_cnt   <= 2'd0;
            addr       <= 32'h0;
            wdata      <= 32'h0;
            reply      <= 32'h0;
            reply_left <= 3'd0;
            lat_cnt    <= '0;
            bus_req    <= 1'b0;
            bus_we     <= 1'b0;
            tx_valid   <= 1'b0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (bif.rx_valid_i && dropping_c) begin
                overrun <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (bif.rx_valid_i) begin
                        busy <= 1'b1;
                        if (is_opcode(bif.rx_data_i)) begin
                            is_write <= (bif.rx_data_i == OP_WRITE);
                            byte_cnt <= 2'd0;
                            state    <= ST_ADDR;
                        end else begin
                            reply      <= {RSP_ERR, 24'h000000};
                            reply_left <= 3'(ACK_BYTES);
                            tx_valid   <= 1'b1;
                            state      <= ST_RESP;
                        end
                    end
                end
                ST_ADDR: begin
                    if (bif.rx_valid_i) begin
                        addr     <= {addr[23:0], bif.rx_data_i};
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'(ADDR_BYTES - 1)) begin
                            byte_cnt <= 2'd0;
                            if (is_write) begin
                                state <= ST_DATA;
                            end else begin
                                state   <= ST_REQ;
                                bus_req <= 1'b1;
                            end
                        end
                    end else if (timeout_c) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                ST_DATA: begin
                    if (bif.rx_valid_i) begin
                        wdata    <= {wdata[23:0], bif.rx_data_i};
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'(DATA_BYTES - 1)) begin
                            byte_cnt <= 2'd0;
                            state    <= ST_REQ;
                            bus_req  <= 1'b1;
                        end
                    end else if (timeout_c) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                ST_REQ: begin
                    if (bif.bus_gnt_i) begin
                        if (is_write) begin
                            bus_we <= 1'b1;
                            state  <= ST_WRITE;
                        end else begin
                            lat_cnt <= '0;
                            state   <= ST_RDWAIT;
                        end
                    end
                end
                ST_WRITE: begin
                    bus_we     <= 1'b0;
                    bus_req    <= 1'b0;
                    reply      <= {RSP_OK, 24'h000000};
                    reply_left <= 3'(ACK_BYTES);
                    tx_valid   <= 1'b1;
                    state      <= ST_RESP;
                end
                ST_RDWAIT: begin
                    // Read data is sampled in the last counted latency cycle.
                    if (lat_cnt == LAT_W'(READ_LATENCY - 1)) begin
                        reply      <= bif.bus_rdata_i;
                        reply_left <= 3'(RD_REPLY_BYTES);
                        bus_req    <= 1'b0;
                        tx_valid   <= 1'b1;
                        state      <= ST_RESP;
                    end else begin
                        lat_cnt <= lat_cnt + LAT_W'(1);
                    end
                end
                ST_RESP: begin
                    if (bif.tx_ready_i) begin
                        if (reply_left == 3'd1) begin
                            reply      <= 32'h0;
                            reply_left <= 3'd0;
                            tx_valid   <= 1'b0;
                            busy       <= 1'b0;
                            state      <= ST_IDLE;
                        end else begin
                            reply      <= {reply[23:0], 8'h00};
                            reply_left <= reply_left - 3'd1;
                        end
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    bus_req  <= 1'b0;
                    bus_we   <= 1'b0;
                    tx_valid <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

    assign bif.tx_data_o   = reply[31:24];
    assign bif.tx_valid_o  = tx_valid;
    assign bif.bus_req_o   = bus_req;
    assign bif.bus_addr_o  = addr;
    assign bif.bus_wdata_o = wdata;
    assign bif.bus_we_o    = bus_we;
    assign bif.busy_o      = busy;
    assign bif.overrun_o   = overrun;

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Bench for uart_bus_bridge: two instances (read latency 1 and 3) share one UART stimulus.
module tb_uart_bus_bridge;

    localparam int unsigned TO = 64;

    typedef struct {
        logic [7:0]  op;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp_rd;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        tx_ready = 1'b1;
    logic        gnt = 1'b1;

    uart_bus_bridge_if if1();
    uart_bus_bridge_if if3();

    uart_bus_bridge #(.TIMEOUT_CYCLES(TO), .READ_LATENCY(1)) u_dut1 (.clk(clk), .reset(reset), .bif(if1));
    uart_bus_bridge #(.TIMEOUT_CYCLES(TO), .READ_LATENCY(3)) u_dut3 (.clk(clk), .reset(reset), .bif(if3));

    always #5 clk = ~clk;

    assign if1.rx_data_i = rx_data;  assign if3.rx_data_i = rx_data;
    assign if1.rx_valid_i = rx_valid; assign if3.rx_valid_i = rx_valid;
    assign if1.tx_ready_i = tx_ready; assign if3.tx_ready_i = tx_ready;
    assign if1.bus_gnt_i = gnt;      assign if3.bus_gnt_i = gnt;

    // Tagged 8-entry memories; untouched addresses read 0 except the 0x2000 pattern.
    logic [31:0] m1_a [8]; logic [31:0] m1_d [8]; logic m1_v [8] = '{default: 1'b0};
    logic [31:0] m3_a [8]; logic [31:0] m3_d [8]; logic m3_v [8] = '{default: 1'b0};
    logic [31:0] rd1 = 32'h0;
    logic [31:0] p3_0 = 32'h0, p3_1 = 32'h0, p3_2 = 32'h0;

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return (a == 32'h0000_2000) ? 32'h0000_A55A : 32'h0;
    endfunction

    always @(posedge clk) begin
        if (if1.bus_we_o) begin
            m1_a[if1.bus_addr_o[4:2]] <= if1.bus_addr_o;
            m1_d[if1.bus_addr_o[4:2]] <= if1.bus_wdata_o;
            m1_v[if1.bus_addr_o[4:2]] <= 1'b1;
        end
        if (if1.bus_req_o && gnt && !if1.bus_we_o)
            rd1 <= (m1_v[if1.bus_addr_o[4:2]] && m1_a[if1.bus_addr_o[4:2]] == if1.bus_addr_o)
                   ? m1_d[if1.bus_addr_o[4:2]] : dflt(if1.bus_addr_o);
        else
            rd1 <= 32'hBAD0_BAD0;
    end

    always @(posedge clk) begin
        if (if3.bus_we_o) begin
            m3_a[if3.bus_addr_o[4:2]] <= if3.bus_addr_o;
            m3_d[if3.bus_addr_o[4:2]] <= if3.bus_wdata_o;
            m3_v[if3.bus_addr_o[4:2]] <= 1'b1;
        end
        if (if3.bus_req_o && gnt && !if3.bus_we_o)
            p3_0 <= (m3_v[if3.bus_addr_o[4:2]] && m3_a[if3.bus_addr_o[4:2]] == if3.bus_addr_o)
                    ? m3_d[if3.bus_addr_o[4:2]] : dflt(if3.bus_addr_o);
        else
            p3_0 <= 32'hBAD0_BAD0;
        p3_1 <= p3_0;
        p3_2 <= p3_1;
    end

    assign if1.bus_rdata_i = rd1;
    assign if3.bus_rdata_i = p3_2;

    int checks = 0;
    int errors = 0;
    int wr_cnt1 = 0, wr_cnt3 = 0, tx_cnt1 = 0, tx_cnt3 = 0, req_cyc1 = 0, req_cyc3 = 0;
    logic [7:0]  exp_tx1 [$];
    logic [7:0]  exp_tx3 [$];
    logic [63:0] exp_wr1 [$];
    logic [63:0] exp_wr3 [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Inputs are already set for the coming edge; observe, then advance one cycle.
    task automatic tick();
        logic [63:0] e;
        if (if1.bus_req_o) req_cyc1++;
        if (if3.bus_req_o) req_cyc3++;
        if (if1.bus_we_o) begin
            wr_cnt1++;
            if (exp_wr1.size() == 0) chk("unexpected_wr1", if1.bus_addr_o, 32'hFFFF_FFFF ^ if1.bus_addr_o);
            else begin
                e = exp_wr1.pop_front();
                chk("wr1_addr", if1.bus_addr_o, e[63:32]);
                chk("wr1_data", if1.bus_wdata_o, e[31:0]);
            end
        end
        if (if3.bus_we_o) begin
            wr_cnt3++;
            if (exp_wr3.size() == 0) chk("unexpected_wr3", if3.bus_addr_o, 32'hFFFF_FFFF ^ if3.bus_addr_o);
            else begin
                e = exp_wr3.pop_front();
                chk("wr3_addr", if3.bus_addr_o, e[63:32]);
                chk("wr3_data", if3.bus_wdata_o, e[31:0]);
            end
        end
        if (if1.tx_valid_o && tx_ready) begin
            tx_cnt1++;
            if (exp_tx1.size() == 0) chk("unexpected_tx1", 32'(if1.tx_data_o), 32'h100);
            else chk("tx1_byte", 32'(if1.tx_data_o), 32'(exp_tx1.pop_front()));
        end
        if (if3.tx_valid_o && tx_ready) begin
            tx_cnt3++;
            if (exp_tx3.size() == 0) chk("unexpected_tx3", 32'(if3.tx_data_o), 32'h100);
            else chk("tx3_byte", 32'(if3.tx_data_o), 32'(exp_tx3.pop_front()));
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b);
        rx_data = b; rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0; rx_data = 8'h00;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send(w[i*8 +: 8]);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((if1.busy_o || if3.busy_o) && n < budget) begin
            tick();
            n++;
        end
        chk("idle_within_budget", 32'(if1.busy_o | if3.busy_o), 32'h0);
    endtask

    task automatic push_tx(input logic [7:0] b);
        exp_tx1.push_back(b);
        exp_tx3.push_back(b);
    endtask

    task automatic run_vec(input vec_t v);
        int w1 = wr_cnt1, w3 = wr_cnt3;
        int exp_w = 0;
        if (v.op == 8'h57) begin
            exp_wr1.push_back({v.addr, v.data});
            exp_wr3.push_back({v.addr, v.data});
            push_tx(8'h4B);
            exp_w = 1;
        end else if (v.op == 8'h52) begin
            for (int i = 3; i >= 0; i--) push_tx(v.exp_rd[i*8 +: 8]);
        end else begin
            push_tx(8'h3F);
        end
        send(v.op);
        if (v.op == 8'h57 || v.op == 8'h52) send_word(v.addr);
        if (v.op == 8'h57) send_word(v.data);
        wait_idle(200);
        chk("wr_pulses1", 32'(wr_cnt1 - w1), 32'(exp_w));
        chk("wr_pulses3", 32'(wr_cnt3 - w3), 32'(exp_w));
        chk("txq1_drained", 32'(exp_tx1.size()), 32'h0);
        chk("txq3_drained", 32'(exp_tx3.size()), 32'h0);
    endtask

    vec_t vecs [7];

    initial begin
        int bad, t1, t3, r1, r3, w1, w3;
        vecs[0] = '{op: 8'h57, addr: 32'h0000_1004, data: 32'hDEAD_BEEF, exp_rd: 32'h0};
        vecs[1] = '{op: 8'h52, addr: 32'h0000_2000, data: 32'h0,         exp_rd: 32'h0000_A55A};
        vecs[2] = '{op: 8'h52, addr: 32'h0000_1004, data: 32'h0,         exp_rd: 32'hDEAD_BEEF};
        vecs[3] = '{op: 8'h57, addr: 32'hFFFF_FFFC, data: 32'h1234_5678, exp_rd: 32'h0};
        vecs[4] = '{op: 8'h52, addr: 32'hFFFF_FFFC, data: 32'h0,         exp_rd: 32'h1234_5678};
        vecs[5] = '{op: 8'h41, addr: 32'h0,         data: 32'h0,         exp_rd: 32'h0};
        vecs[6] = '{op: 8'h52, addr: 32'h0000_1000, data: 32'h0,         exp_rd: 32'h0};

        @(negedge clk);
        repeat (3) tick();
        reset = 1'b0;
        chk("rst_busy", 32'(if1.busy_o), 0);
        chk("rst_req", 32'(if1.bus_req_o), 0);
        chk("rst_we", 32'(if1.bus_we_o), 0);
        chk("rst_txv", 32'(if1.tx_valid_o), 0);
        chk("rst_overrun", 32'(if1.overrun_o), 0);
        chk("rst_addr", if1.bus_addr_o, 0);
        chk("rst_busy3", 32'(if3.busy_o), 0);

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Grant stall on a write: request held, no access until grant returns.
        gnt = 1'b0;
        exp_wr1.push_back({32'h0000_3000, 32'hCAFE_F00D});
        exp_wr3.push_back({32'h0000_3000, 32'hCAFE_F00D});
        push_tx(8'h4B);
        send(8'h57); send_word(32'h0000_3000); send_word(32'hCAFE_F00D);
        bad = 0; w1 = wr_cnt1;
        for (int i = 0; i < 50; i++) begin
            if (!if1.bus_req_o || !if3.bus_req_o || if1.bus_we_o || if3.bus_we_o) bad++;
            tick();
        end
        chk("stall_req_held", 32'(bad), 0);
        chk("stall_no_access", 32'(wr_cnt1 - w1), 0);
        gnt = 1'b1;
        tick();
        chk("stall_we1_after_gnt", 32'(if1.bus_we_o), 1);
        chk("stall_we3_after_gnt", 32'(if3.bus_we_o), 1);
        wait_idle(200);
        chk("stall_txq_drained", 32'(exp_tx1.size() + exp_tx3.size()), 0);

        // Backpressure during a read reply, with a stray byte arriving meanwhile.
        tx_ready = 1'b0;
        for (int i = 3; i >= 0; i--) push_tx(8'(32'hDEAD_BEEF >> (i*8)));
        send(8'h52); send_word(32'h0000_1004);
        repeat (10) tick();
        chk("bp_overrun_before", 32'(if1.overrun_o | if3.overrun_o), 0);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            rx_valid = (i == 5); rx_data = (i == 5) ? 8'h41 : 8'h00;
            if (!if1.tx_valid_o || if1.tx_data_o != 8'hDE || !if3.tx_valid_o || if3.tx_data_o != 8'hDE) bad++;
            tick();
        end
        rx_valid = 1'b0;
        chk("bp_tx_stable", 32'(bad), 0);
        chk("bp_overrun1", 32'(if1.overrun_o), 1);
        chk("bp_overrun3", 32'(if3.overrun_o), 1);
        tx_ready = 1'b1;
        wait_idle(200);
        chk("bp_txq_drained", 32'(exp_tx1.size() + exp_tx3.size()), 0);

        // Partial frame abandoned by the inter-byte timeout.
        t1 = tx_cnt1; t3 = tx_cnt3; r1 = req_cyc1; r3 = req_cyc3;
        send(8'h57); send(8'h00); send(8'h00);
        repeat (TO - 3) tick();
        chk("to_still_busy", 32'(if1.busy_o & if3.busy_o), 1);
        repeat (8) tick();
        chk("to_idle", 32'(if1.busy_o | if3.busy_o), 0);
        chk("to_no_bus", 32'((req_cyc1 - r1) + (req_cyc3 - r3)), 0);
        chk("to_no_tx", 32'((tx_cnt1 - t1) + (tx_cnt3 - t3)), 0);
        run_vec('{op: 8'h57, addr: 32'h0000_0010, data: 32'hA5A5_0F0F, exp_rd: 32'h0});

        // Reset during the data phase: no write may escape.
        w1 = wr_cnt1; w3 = wr_cnt3;
        send(8'h57); send_word(32'h0000_1004); send(8'hDE); send(8'hAD);
        reset = 1'b1;
        tick();
        chk("rstd_busy", 32'(if1.busy_o | if3.busy_o), 0);
        chk("rstd_req", 32'(if1.bus_req_o | if3.bus_req_o), 0);
        chk("rstd_overrun", 32'(if1.overrun_o | if3.overrun_o), 0);
        chk("rstd_wdata", if1.bus_wdata_o, 0);
        reset = 1'b0;
        tick();
        chk("rstd_no_write", 32'((wr_cnt1 - w1) + (wr_cnt3 - w3)), 0);

        // Reset while a reply is stalled by the transmitter.
        tx_ready = 1'b0;
        send(8'h41);
        tick();
        chk("rstr_txv_before", 32'(if1.tx_valid_o), 1);
        chk("rstr_txd_before", 32'(if1.tx_data_o), 32'h3F);
        reset = 1'b1;
        tick();
        chk("rstr_txv", 32'(if1.tx_valid_o | if3.tx_valid_o), 0);
        chk("rstr_txd", 32'(if1.tx_data_o), 0);
        chk("rstr_busy", 32'(if1.busy_o | if3.busy_o), 0);
        reset = 1'b0;
        tx_ready = 1'b1;
        tick();
        run_vec('{op: 8'h57, addr: 32'h0000_0040, data: 32'h1122_3344, exp_rd: 32'h0});
        run_vec('{op: 8'h52, addr: 32'h0000_0040, data: 32'h0, exp_rd: 32'h1122_3344});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
